// File: rtl/peripheral_dbg_soc_ring_router_gateway_mux.sv
// Three-way worm-preserving merge of ring, local and external-gateway debug flits
// onto a single registered ring output.
package peripheral_dbg_soc_ring_router_gateway_mux_pkg;
  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic        valid;
  } dii_flit;
endpackage

module peripheral_dbg_soc_ring_router_gateway_mux
  import peripheral_dbg_soc_ring_router_gateway_mux_pkg::*;
#(
  parameter int unsigned RING_PRIORITY = 0
) (
  input  logic    clk,
  input  logic    rst,
  input  dii_flit in_ring,
  input  dii_flit in_local,
  input  dii_flit in_ext,
  output logic    in_ring_ready,
  output logic    in_local_ready,
  output logic    in_ext_ready,
  output dii_flit out_ring,
  input  logic    out_ring_ready
);

  typedef enum logic {IDLE, LOCKED} state_e;

  localparam logic [1:0] SRC_RING  = 2'd0;
  localparam logic [1:0] SRC_LOCAL = 2'd1;
  localparam logic [1:0] SRC_EXT   = 2'd2;

  state_e     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] last_grant_q, last_grant_d;
  dii_flit    out_q, out_d;

  // Fourth slot is a tied-off dummy so a 2-bit select never indexes past the array.
  dii_flit    in_arr [4];
  logic [3:0] in_valid;
  logic [2:0] ready_vec;
  logic [1:0] sel;
  logic [1:0] cand;
  logic       sel_vld;
  logic       can_load;
  logic       accept;
  dii_flit    gflit;

  function automatic logic [1:0] next_src(input logic [1:0] s);
    return (s == SRC_EXT) ? SRC_RING : s + 2'd1;
  endfunction

  assign in_arr[0] = in_ring;
  assign in_arr[1] = in_local;
  assign in_arr[2] = in_ext;
  assign in_arr[3] = '0;
  assign in_valid  = {1'b0, in_ext.valid, in_local.valid, in_ring.valid};

  // Source selection: locked worms keep their source, otherwise arbitrate afresh.
  always_comb begin
    sel     = grant_q;
    sel_vld = 1'b0;
    cand    = next_src(last_grant_q);
    if (state_q == LOCKED) begin
      sel     = grant_q;
      sel_vld = 1'b1;
    end else if (RING_PRIORITY != 0) begin
      if (in_ring.valid) begin
        sel     = SRC_RING;
        sel_vld = 1'b1;
      end else if (in_local.valid) begin
        sel     = SRC_LOCAL;
        sel_vld = 1'b1;
      end else if (in_ext.valid) begin
        sel     = SRC_EXT;
        sel_vld = 1'b1;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (!sel_vld && in_valid[cand]) begin
          sel     = cand;
          sel_vld = 1'b1;
        end
        cand = next_src(cand);
      end
    end
  end

  // Readies are forced low while reset is held, independent of the input valids.
  assign can_load = rst & (~out_q.valid | out_ring_ready);
  assign gflit    = in_arr[sel];
  assign accept   = can_load & sel_vld & gflit.valid;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_ready
      assign ready_vec[gi] = sel_vld && (sel == 2'(gi)) && can_load;
    end
  endgenerate

  assign in_ring_ready  = ready_vec[0];
  assign in_local_ready = ready_vec[1];
  assign in_ext_ready   = ready_vec[2];
  assign out_ring       = out_q;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    out_d        = out_q;
    if (accept) begin
      out_d       = gflit;
      out_d.valid = 1'b1;
      if (state_q == IDLE) begin
        last_grant_d = sel;
        if (!gflit.last) begin
          state_d = LOCKED;
          grant_d = sel;
        end
      end else if (gflit.last) begin
        state_d = IDLE;
      end
    end else if (out_ring_ready) begin
      out_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      grant_q      <= SRC_RING;
      last_grant_q <= SRC_EXT;
      out_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      out_q        <= out_d;
    end
  end

endmodule

// File: tb/tb_peripheral_dbg_soc_ring_router_gateway_mux.sv
// Directed stimulus with a scoreboard; a negedge monitor pops expected flits as they leave.
module tb_peripheral_dbg_soc_ring_router_gateway_mux;
  import peripheral_dbg_soc_ring_router_gateway_mux_pkg::*;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  dii_flit in_ring, in_local, in_ext, out_ring;
  logic    in_ring_ready, in_local_ready, in_ext_ready, out_ring_ready;
  dii_flit p_ring, p_local, p_ext, p_out;
  logic    p_ring_ready, p_local_ready, p_ext_ready, p_out_ready;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } exp_t;

  dii_flit q0[$], q1[$], q2[$];
  exp_t    exp_q[$];
  int      out_cyc[$];
  int      cyc = 0;
  int      total = 0;
  int      bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  peripheral_dbg_soc_ring_router_gateway_mux #(.RING_PRIORITY(0)) dut (
    .clk(clk), .rst(rst),
    .in_ring(in_ring), .in_local(in_local), .in_ext(in_ext),
    .in_ring_ready(in_ring_ready), .in_local_ready(in_local_ready), .in_ext_ready(in_ext_ready),
    .out_ring(out_ring), .out_ring_ready(out_ring_ready)
  );

  peripheral_dbg_soc_ring_router_gateway_mux #(.RING_PRIORITY(1)) dut_p (
    .clk(clk), .rst(rst),
    .in_ring(p_ring), .in_local(p_local), .in_ext(p_ext),
    .in_ring_ready(p_ring_ready), .in_local_ready(p_local_ready), .in_ext_ready(p_ext_ready),
    .out_ring(p_out), .out_ring_ready(p_out_ready)
  );

  function automatic dii_flit mk(input logic [15:0] d, input logic l);
    dii_flit f;
    f.data  = d;
    f.last  = l;
    f.valid = 1'b1;
    return f;
  endfunction

  task automatic src(input int s, input logic [15:0] d, input logic l);
    if (s == 0) q0.push_back(mk(d, l));
    else if (s == 1) q1.push_back(mk(d, l));
    else q2.push_back(mk(d, l));
  endtask

  task automatic expect_out(input logic [15:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic drive();
    if (q0.size() != 0) in_ring = q0[0]; else in_ring = '0;
    if (q1.size() != 0) in_local = q1[0]; else in_local = '0;
    if (q2.size() != 0) in_ext = q2[0]; else in_ext = '0;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // One clock: handshakes are judged at the negedge, queues advance just after the posedge.
  task automatic step();
    logic a0, a1, a2;
    @(negedge clk);
    a0 = in_ring.valid && in_ring_ready;
    a1 = in_local.valid && in_local_ready;
    a2 = in_ext.valid && in_ext_ready;
    @(posedge clk);
    #1;
    if (a0) void'(q0.pop_front());
    if (a1) void'(q1.pop_front());
    if (a2) void'(q2.pop_front());
    drive();
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q0.size() + q1.size() + q2.size() + exp_q.size()) != 0 && n < 60) begin
      step();
      n++;
    end
    total++;
    if (n >= 60) begin
      bad++;
      $display("FAIL %s_timeout got=pending%0d want=0", name, q0.size() + q1.size() + q2.size() + exp_q.size());
    end
  endtask

  task automatic check_consec(input string name, input int n);
    check({name, "_count"}, out_cyc.size(), n);
    for (int i = 1; i < n && i < out_cyc.size(); i++)
      check({name, "_gap"}, out_cyc[i] - out_cyc[i-1], 1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && out_ring.valid && out_ring_ready) begin
        out_cyc.push_back(cyc);
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL out_unexpected got=%h/%b want=none", out_ring.data, out_ring.last);
        end else begin
          e = exp_q.pop_front();
          if (out_ring.data !== e.data || out_ring.last !== e.last) begin
            bad++;
            $display("FAIL out_flit got=%h/%b want=%h/%b", out_ring.data, out_ring.last, e.data, e.last);
          end else begin
            $display("out flit %h last=%b at cycle %0d", out_ring.data, out_ring.last, cyc);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int viol;
    int k;
    out_ring_ready = 1'b1;
    p_out_ready    = 1'b1;
    p_ring = '0; p_local = '0; p_ext = '0;
    drive();
    #1 rst = 1'b0;

    // Reset with all sources valid: nothing may be accepted or emitted.
    src(0, 16'h0A01, 1'b1);
    src(1, 16'h0B01, 1'b1);
    src(2, 16'h0C01, 1'b1);
    drive();
    @(posedge clk); #2;
    check("rst_out_valid", out_ring.valid, 0);
    check("rst_out_data", out_ring.data, 0);
    check("rst_ring_ready", in_ring_ready, 0);
    check("rst_local_ready", in_local_ready, 0);
    check("rst_ext_ready", in_ext_ready, 0);

    // Round robin after reset starts at ring (last_grant resets to ext).
    expect_out(16'h0A01, 1'b1);
    expect_out(16'h0B01, 1'b1);
    expect_out(16'h0C01, 1'b1);
    out_cyc.delete();
    rst = 1'b1;
    step();
    check("first_out_latency", out_ring.valid, 1);
    drain("rr3");
    check_consec("rr3", 3);

    // Local worm holds the output; ring joins one cycle later and waits.
    for (int i = 1; i <= 4; i++) begin
      src(1, 16'h0100 + 16'(i), (i == 4));
      expect_out(16'h0100 + 16'(i), (i == 4));
    end
    expect_out(16'h0AAA, 1'b1);
    out_cyc.delete();
    drive();
    #1;
    viol = 0;
    k = 0;
    while (q1.size() != 0 && k < 20) begin
      if (in_ring_ready) viol++;
      step();
      if (k == 0) begin
        src(0, 16'h0AAA, 1'b1);
        drive();
        #1;
      end
      k++;
    end
    check("worm_ring_ready", viol, 0);
    drain("worm");
    check_consec("worm", 5);

    // Downstream stall mid-worm freezes the output register.
    src(2, 16'h0E01, 1'b0); expect_out(16'h0E01, 1'b0);
    src(2, 16'h0E02, 1'b0); expect_out(16'h0E02, 1'b0);
    src(2, 16'h0E03, 1'b1); expect_out(16'h0E03, 1'b1);
    drive();
    step();
    step();
    out_ring_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_data", out_ring.data, 16'h0E02);
      check("stall_last", out_ring.last, 0);
      check("stall_valid", out_ring.valid, 1);
      check("stall_ext_ready", in_ext_ready, 0);
    end
    out_ring_ready = 1'b1;
    drain("stall");

    // Strict ring priority: local never gets through.
    for (int i = 0; i < 6; i++) begin
      p_ring  = mk(16'h2000 + 16'(i), 1'b1);
      p_local = mk(16'hBEEF, 1'b1);
      #1;
      check("prio_local_ready", p_local_ready, 0);
      check("prio_ring_ready", p_ring_ready, 1);
      step();
      check("prio_out", {p_out.valid, p_out.data}, {1'b1, 16'h2000 + 16'(i)});
    end
    p_ring = '0;
    p_local = '0;

    // Asynchronous reset mid ext worm drops the worm; a fresh local flit follows.
    src(2, 16'h3001, 1'b0); expect_out(16'h3001, 1'b0);
    src(2, 16'h3002, 1'b0);
    src(2, 16'h3003, 1'b1);
    drive();
    step();
    step();
    #1 rst = 1'b0;
    #1;
    check("async_rst_valid", out_ring.valid, 0);
    check("async_rst_ext_ready", in_ext_ready, 0);
    q2.delete();
    drive();
    @(posedge clk);
    #3 rst = 1'b1;
    src(1, 16'h4001, 1'b1); expect_out(16'h4001, 1'b1);
    drive();
    drain("post_rst");

    // Back-to-back worms: ext pair then local single, no bubble.
    src(2, 16'h5001, 1'b0); expect_out(16'h5001, 1'b0);
    src(2, 16'h5002, 1'b1); expect_out(16'h5002, 1'b1);
    src(1, 16'h5003, 1'b1); expect_out(16'h5003, 1'b1);
    out_cyc.delete();
    drive();
    drain("b2b");
    check_consec("b2b", 3);

    repeat (3) step();
    check("exp_left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
